multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile.sv | 98 +++++++++
 tb/tb_multiport_regfile.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module   : multiport_regfile
// Brief    : Two-read / one-write register file with scoreboard-based RAW
//            hazard detection, write-to-read bypass and hardwired-zero r0.
// Revision : 1.0 - initial release
// ============================================================================
module multiport_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [ADDR_WIDTH-1:0] rd_dst,
  input  logic                  rd_dst_set,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  pending_any
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic [c_DEPTH-1:0]    r_pending;

  logic                  w_wrHitA;
  logic                  w_wrHitB;
  logic                  w_stallA;
  logic                  w_stallB;
  logic                  w_accept;
  logic                  w_setPend;
  logic [DATA_WIDTH-1:0] w_opA;
  logic [DATA_WIDTH-1:0] w_opB;

  assign w_wrHitA = wr_en && (wr_addr == rd_addr_a);
  assign w_wrHitB = wr_en && (wr_addr == rd_addr_b);

  // A pending source is only safe if its producer is writing back right now.
  assign w_stallA = r_pending[rd_addr_a] && !w_wrHitA;
  assign w_stallB = r_pending[rd_addr_b] && !w_wrHitB;
  assign rd_ready = !(w_stallA || w_stallB);

  assign w_accept  = rd_req && rd_ready;
  assign w_setPend = w_accept && rd_dst_set && (rd_dst != '0);

  assign w_opA = (rd_addr_a == '0) ? '0 : (w_wrHitA ? wr_data : r_regs[rd_addr_a]);
  assign w_opB = (rd_addr_b == '0) ? '0 : (w_wrHitB ? wr_data : r_regs[rd_addr_b]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Set is issued after clear so a new producer overrides a retiring one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      if (wr_en) begin
        r_pending[wr_addr] <= 1'b0;
      end
      if (w_setPend) begin
        r_pending[rd_dst] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid    <= 1'b0;
      rd_data_a   <= '0;
      rd_data_b   <= '0;
      pending_any <= 1'b0;
    end else begin
      rd_valid    <= w_accept;
      pending_any <= |r_pending;
      if (w_accept) begin
        rd_data_a <= w_opA;
        rd_data_b <= w_opB;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiport_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiport_regfile
// Brief    : Self-checking bench for multiport_regfile against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiport_regfile;

  localparam int c_DW = 64;
  localparam int c_AW = 5;
  localparam int c_DEPTH = 32;

  logic            clk;
  logic            rst_n;
  logic            rd_req;
  logic [c_AW-1:0] rd_addr_a;
  logic [c_AW-1:0] rd_addr_b;
  logic [c_AW-1:0] rd_dst;
  logic            rd_dst_set;
  logic            rd_ready;
  logic            rd_valid;
  logic [c_DW-1:0] rd_data_a;
  logic [c_DW-1:0] rd_data_b;
  logic            wr_en;
  logic [c_AW-1:0] wr_addr;
  logic [c_DW-1:0] wr_data;
  logic            pending_any;

  multiport_regfile #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rd_dst(rd_dst), .rd_dst_set(rd_dst_set),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pending_any(pending_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register contents and producer scoreboard.
  logic [c_DW-1:0] mMem [c_DEPTH];
  bit              mPend [c_DEPTH];
  logic [c_DW-1:0] expA, expB;
  logic            expValid, expAny;
  logic            sampledReady;

  task automatic checkVal(input string tag, input logic [c_DW-1:0] got, input logic [c_DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit anyPending();
    bit r = 0;
    for (int i = 0; i < c_DEPTH; i++) r |= mPend[i];
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < c_DEPTH; i++) begin
      mMem[i] = '0;
      mPend[i] = 0;
    end
    expA = '0; expB = '0; expValid = 0; expAny = 0;
  endtask

  task automatic setInputs(input logic req, input logic [c_AW-1:0] a, input logic [c_AW-1:0] b,
                           input logic [c_AW-1:0] dst, input logic dstSet, input logic we,
                           input logic [c_AW-1:0] wa, input logic [c_DW-1:0] wd);
    rd_req = req; rd_addr_a = a; rd_addr_b = b; rd_dst = dst; rd_dst_set = dstSet;
    wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic doCycle(input logic req, input logic [c_AW-1:0] a, input logic [c_AW-1:0] b,
                         input logic [c_AW-1:0] dst, input logic dstSet, input logic we,
                         input logic [c_AW-1:0] wa, input logic [c_DW-1:0] wd);
    bit expReady, acc, oldAny;
    setInputs(req, a, b, dst, dstSet, we, wa, wd);
    #3;
    expReady = !((mPend[a] && !(we && wa == a)) || (mPend[b] && !(we && wa == b)));
    sampledReady = rd_ready;
    checkVal("ready", {63'b0, rd_ready}, {63'b0, expReady});
    @(posedge clk);
    acc = req && expReady;
    if (acc) begin
      expA = (a == 0) ? '0 : ((we && wa == a) ? wd : mMem[a]);
      expB = (b == 0) ? '0 : ((we && wa == b) ? wd : mMem[b]);
    end
    expValid = acc;
    if (we && wa != 0) mMem[wa] = wd;
    oldAny = anyPending();
    if (we) mPend[wa] = 0;
    if (acc && dstSet && dst != 0) mPend[dst] = 1;
    expAny = oldAny;
    #1;
    checkVal("valid", {63'b0, rd_valid}, {63'b0, expValid});
    checkVal("dataA", rd_data_a, expA);
    checkVal("dataB", rd_data_b, expB);
    checkVal("pendAny", {63'b0, pending_any}, {63'b0, expAny});
  endtask

  task automatic idle();
    doCycle(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("rstValid", {63'b0, rd_valid}, 64'd0);
    checkVal("rstDataA", rd_data_a, 64'd0);
    checkVal("rstDataB", rd_data_b, 64'd0);
    checkVal("rstPendAny", {63'b0, pending_any}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    setInputs(0, 0, 0, 0, 0, 0, 0, '0);
    applyReset();

    // Reset clears previously written registers
    doCycle(0, 0, 0, 0, 0, 1, 1, 64'hAAAA);
    doCycle(0, 0, 0, 0, 0, 1, 31, 64'hBBBB);
    applyReset();
    doCycle(1, 1, 31, 0, 0, 0, 0, '0);
    checkVal("rstR1", rd_data_a, 64'd0);
    checkVal("rstR31", rd_data_b, 64'd0);
    checkVal("rstRdValid", {63'b0, rd_valid}, 64'd1);

    // Basic write then read
    doCycle(0, 0, 0, 0, 0, 1, 5, 64'hDEAD_BEEF);
    doCycle(1, 5, 0, 0, 0, 0, 0, '0);
    checkVal("basicA", rd_data_a, 64'hDEAD_BEEF);
    checkVal("basicB", rd_data_b, 64'd0);
    idle();
    checkVal("holdA", rd_data_a, 64'hDEAD_BEEF);

    // Bypass
    doCycle(1, 7, 0, 0, 0, 1, 7, 64'h1234);
    checkVal("bypReady", {63'b0, sampledReady}, 64'd1);
    checkVal("bypA", rd_data_a, 64'h1234);

    // RAW hazard on r3, released by its writeback
    doCycle(1, 0, 0, 3, 1, 0, 0, '0);
    doCycle(1, 3, 0, 0, 0, 0, 0, '0);
    checkVal("hazStall1", {63'b0, sampledReady}, 64'd0);
    doCycle(1, 3, 0, 0, 0, 0, 0, '0);
    checkVal("hazStall2", {63'b0, sampledReady}, 64'd0);
    doCycle(1, 3, 0, 0, 0, 1, 3, 64'h55);
    checkVal("hazRelease", {63'b0, sampledReady}, 64'd1);
    checkVal("hazData", rd_data_a, 64'h55);

    // Set/clear collision on r9
    doCycle(1, 0, 0, 9, 1, 1, 9, 64'h77);
    idle();
    checkVal("colPendAny", {63'b0, pending_any}, 64'd1);
    doCycle(1, 9, 0, 0, 0, 0, 0, '0);
    checkVal("colStall", {63'b0, sampledReady}, 64'd0);
    doCycle(0, 0, 0, 0, 0, 1, 9, 64'h99);
    idle();
    idle();
    checkVal("colCleared", {63'b0, pending_any}, 64'd0);

    // r0 immunity
    doCycle(0, 0, 0, 0, 0, 1, 0, 64'hFFFF);
    doCycle(1, 0, 0, 0, 1, 0, 0, '0);
    checkVal("r0Read", rd_data_a, 64'd0);
    idle();
    idle();
    checkVal("r0Pend", {63'b0, pending_any}, 64'd0);

    // Reset in the middle of an accept cycle
    doCycle(0, 0, 0, 0, 0, 1, 4, 64'h4444);
    setInputs(1, 4, 4, 6, 1, 1, 4, 64'h5555);
    #3;
    applyReset();
    idle();
    checkVal("abortValid", {63'b0, rd_valid}, 64'd0);
    checkVal("abortData", rd_data_a, 64'd0);
    doCycle(1, 4, 6, 0, 0, 0, 0, '0);
    checkVal("abortR4", rd_data_a, 64'd0);

    // Randomized traffic over a small address window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      logic [c_AW-1:0] a, b, d, w;
      logic [c_DW-1:0] wd;
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      a = narrow ? c_AW'($urandom_range(0, 7)) : c_AW'($urandom);
      b = narrow ? c_AW'($urandom_range(0, 7)) : c_AW'($urandom);
      d = narrow ? c_AW'($urandom_range(0, 7)) : c_AW'($urandom);
      w = narrow ? c_AW'($urandom_range(0, 7)) : c_AW'($urandom);
      wd = {$urandom, $urandom};
      doCycle(1'($urandom_range(0, 3) != 0), a, b, d, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), w, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
